// File: rtl/cube_state_store.sv
// cube_state_store: stages 9 classifier sticker codes per face, checks the
// staged face, commits it into a 6x9 cube map and verifies the full cube on
// algstart. The solver reads the map through a 1-cycle registered port.
// Optional build macro COLOR_HIST_EN: per-color counters during verify, the
// pass condition also requires 9 stickers of each color, and the hist_bad
// output port is added.
module cube_state_store #(
    parameter int NFACES = 6,
    parameter int NSTICK = 9,
    parameter int CW     = 3
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          init,
    input  logic          ds,
    input  logic          cs,
    input  logic          cc,
    input  logic          facedone,
    input  logic          algstart,
    input  logic          col_valid,
    input  logic [CW-1:0] col_code,
    output logic          col_ready,
    output logic          chk_done,
    output logic          chk_ok,
    output logic [2:0]    face_idx,
    output logic          cube_valid,
    output logic          cube_err,
    input  logic [5:0]    rd_addr,
    output logic [CW-1:0] rd_color
`ifdef COLOR_HIST_EN
    ,output logic [5:0]   hist_bad
`endif
);

    localparam int            NCELL      = NFACES * NSTICK;
    localparam int            CENTER     = (NSTICK - 1) / 2;
    localparam int            NCOLORS    = 6;
    localparam logic [CW-1:0] NONE       = {CW{1'b1}};
    localparam logic [CW-1:0] NCOL_CODE  = CW'(NCOLORS);
    localparam logic [2:0]    FACE_MAX   = 3'(NFACES);
    localparam logic [5:0]    LAST_STICK = 6'(NSTICK - 1);
    localparam logic [5:0]    LAST_CELL  = 6'(NCELL - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        CHECK   = 3'd2,
        VERIFY  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] map_q   [NCELL];
    logic [CW-1:0] stage_q [NSTICK];
    logic [5:0]    cnt_q;
    logic [2:0]    face_idx_q;
    logic          chk_ok_q, chk_done_q, chk_acc_q;
    logic          cube_valid_q, cube_err_q, vfy_ok_q;
    logic          facedone_q, algstart_q;
    logic [CW-1:0] rd_color_q;

    logic          fd_rise, as_rise;
    logic          idle_fd, commit_en, accept;
    logic [NFACES-1:0] center_hit;
    logic [CW-1:0] chk_code, vfy_code;
    logic          chk_entry_ok;
    logic          pass_w;

    assign fd_rise   = facedone && !facedone_q;
    assign as_rise   = algstart && !algstart_q;
    // facedone only acts in IDLE when no higher-priority command is present
    assign idle_fd   = (state_q == IDLE) && !init && !cs && !cc && fd_rise;
    assign commit_en = idle_fd && chk_ok_q && (face_idx_q < FACE_MAX);
    assign accept    = (state_q == CAPTURE) && !cs && col_valid;

    // A staged center collides with the center of any already committed face
    generate
        for (genvar gi = 0; gi < NFACES; gi++) begin : g_center
            assign center_hit[gi] = (3'(gi) < face_idx_q) &&
                                    (map_q[gi * NSTICK + CENTER] == stage_q[CENTER]);
        end
    endgenerate

    assign chk_code     = stage_q[cnt_q[3:0]];
    assign chk_entry_ok = (chk_code < NCOL_CODE) &&
                          !((cnt_q == 6'(CENTER)) && (|center_hit));
    assign vfy_code     = map_q[cnt_q];

`ifdef COLOR_HIST_EN
    logic [3:0] hist_q [NCOLORS];
    logic [5:0] hist_bad_q;
    logic [5:0] hist_bad_w;

    generate
        for (genvar gi = 0; gi < NCOLORS; gi++) begin : g_hist_bad
            assign hist_bad_w[gi] = (hist_q[gi] != 4'd9);
        end
    endgenerate

    assign pass_w   = (face_idx_q == FACE_MAX) && vfy_ok_q && (hist_bad_w == 6'd0);
    assign hist_bad = hist_bad_q;

    // Per-color counters accumulate during the verify scan, latched in DONE
    always_ff @(posedge Clk) begin
        if (Reset || init) begin
            for (int c = 0; c < NCOLORS; c++) hist_q[c] <= 4'd0;
            hist_bad_q <= 6'd0;
        end else if (state_q == IDLE && !cs && !cc && !fd_rise && as_rise) begin
            for (int c = 0; c < NCOLORS; c++) hist_q[c] <= 4'd0;
        end else if (state_q == VERIFY) begin
            if (vfy_code < NCOL_CODE && hist_q[vfy_code] != 4'hF)
                hist_q[vfy_code] <= hist_q[vfy_code] + 4'd1;
        end else if (state_q == DONE) begin
            hist_bad_q <= hist_bad_w;
        end
    end
`else
    assign pass_w = (face_idx_q == FACE_MAX) && vfy_ok_q;
`endif

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; init overrides everything
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cs)                   state_d = CAPTURE;
                else if (cc)              state_d = CHECK;
                else if (fd_rise)         state_d = IDLE;
                else if (as_rise)         state_d = VERIFY;
            end
            CAPTURE: if (accept && cnt_q == LAST_STICK) state_d = IDLE;
            CHECK:   if (cnt_q == LAST_STICK)           state_d = IDLE;
            VERIFY:  if (cnt_q == LAST_CELL)            state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (init) state_d = IDLE;
    end

    // Edge detectors for the level-type facedone/algstart inputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            facedone_q <= 1'b0;
            algstart_q <= 1'b0;
        end else begin
            facedone_q <= facedone;
            algstart_q <= algstart;
        end
    end

    // Staging buffer: capture writes, ds clears (except during verify)
    always_ff @(posedge Clk) begin
        if (Reset || init || (ds && state_q != VERIFY)) begin
            for (int s = 0; s < NSTICK; s++) stage_q[s] <= NONE;
        end else if (accept) begin
            stage_q[cnt_q[3:0]] <= col_code;
        end
    end

    // Cube map: whole staged face copied into its slot in one cycle
    always_ff @(posedge Clk) begin
        if (Reset || init) begin
            for (int i = 0; i < NCELL; i++) map_q[i] <= NONE;
        end else if (commit_en) begin
            for (int f = 0; f < NFACES; f++)
                for (int s = 0; s < NSTICK; s++)
                    if (face_idx_q == 3'(f)) map_q[f * NSTICK + s] <= stage_q[s];
        end
    end

    // Solver read port, out-of-range addresses read as NONE
    always_ff @(posedge Clk) begin
        if (Reset) rd_color_q <= NONE;
        else       rd_color_q <= (rd_addr <= LAST_CELL) ? map_q[rd_addr] : NONE;
    end

    // Counters, face check, commit bookkeeping and verify result
    always_ff @(posedge Clk) begin
        if (Reset || init) begin
            cnt_q        <= 6'd0;
            face_idx_q   <= 3'd0;
            chk_ok_q     <= 1'b0;
            chk_done_q   <= 1'b0;
            chk_acc_q    <= 1'b1;
            cube_valid_q <= 1'b0;
            cube_err_q   <= 1'b0;
            vfy_ok_q     <= 1'b1;
        end else begin
            chk_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs) begin
                        cnt_q <= 6'd0;
                    end else if (cc) begin
                        cnt_q     <= 6'd0;
                        chk_acc_q <= 1'b1;
                    end else if (fd_rise) begin
                        if (face_idx_q == FACE_MAX) begin
                            cube_err_q <= 1'b1;
                        end else if (chk_ok_q) begin
                            face_idx_q <= face_idx_q + 3'd1;
                            chk_ok_q   <= 1'b0;
                        end
                    end else if (as_rise) begin
                        cnt_q    <= 6'd0;
                        vfy_ok_q <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (cs)          cnt_q <= 6'd0;
                    else if (accept) cnt_q <= (cnt_q == LAST_STICK) ? 6'd0 : cnt_q + 6'd1;
                end
                CHECK: begin
                    chk_acc_q <= chk_acc_q && chk_entry_ok;
                    if (cnt_q == LAST_STICK) begin
                        chk_ok_q   <= chk_acc_q && chk_entry_ok;
                        chk_done_q <= 1'b1;
                        cnt_q      <= 6'd0;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                VERIFY: begin
                    if (vfy_code >= NCOL_CODE) vfy_ok_q <= 1'b0;
                    cnt_q <= (cnt_q == LAST_CELL) ? 6'd0 : cnt_q + 6'd1;
                end
                DONE: begin
                    cube_valid_q <= pass_w;
                    if (!pass_w) cube_err_q <= 1'b1;
                end
                default: cnt_q <= 6'd0;
            endcase
            // ds drops a pending check result; it wins over a finishing check
            if (ds && state_q != VERIFY) chk_ok_q <= 1'b0;
        end
    end

    assign col_ready  = (state_q == CAPTURE);
    assign chk_done   = chk_done_q;
    assign chk_ok     = chk_ok_q;
    assign face_idx   = face_idx_q;
    assign cube_valid = cube_valid_q;
    assign cube_err   = cube_err_q;
    assign rd_color   = rd_color_q;

endmodule

// File: tb/tb_cube_state_store.sv
// Directed bench for cube_state_store with a scoreboard queue for read-port
// data, face-check results and verify results.
module tb_cube_state_store;

    logic       Clk = 1'b0;
    logic       Reset, init, ds, cs, cc, facedone, algstart, col_valid;
    logic [2:0] col_code;
    logic       col_ready, chk_done, chk_ok, cube_valid, cube_err;
    logic [2:0] face_idx;
    logic [5:0] rd_addr;
    logic [2:0] rd_color;
`ifdef COLOR_HIST_EN
    logic [5:0] hist_bad;
`endif

    cube_state_store dut (
        .Clk(Clk), .Reset(Reset), .init(init), .ds(ds), .cs(cs), .cc(cc),
        .facedone(facedone), .algstart(algstart),
        .col_valid(col_valid), .col_code(col_code), .col_ready(col_ready),
        .chk_done(chk_done), .chk_ok(chk_ok), .face_idx(face_idx),
        .cube_valid(cube_valid), .cube_err(cube_err),
        .rd_addr(rd_addr), .rd_color(rd_color)
`ifdef COLOR_HIST_EN
        , .hist_bad(hist_bad)
`endif
    );

    always #5 Clk = ~Clk;

    int    errors = 0;
    int    checks = 0;
    int    exp_q[$];
    string tag_q[$];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty: observed=%0d expected=none", obs);
        end else begin
            chk(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic rd(input int addr, input int exp);
        rd_addr = 6'(addr);
        sb_push($sformatf("rd_color[%0d]", addr), exp);
        tick();
        sb_pop(32'(rd_color));
    endtask

    function automatic logic [26:0] solid(input int c);
        logic [2:0] v;
        v = 3'(c);
        return {9{v}};
    endfunction

    task automatic capture(input logic [26:0] codes);
        cs = 1'b1;
        tick();
        cs = 1'b0;
        chk("col_ready_open", 32'(col_ready), 1);
        for (int i = 0; i < 9; i++) begin
            col_valid = 1'b1;
            col_code  = codes[3*i +: 3];
            tick();
        end
        col_valid = 1'b0;
        chk("col_ready_closed", 32'(col_ready), 0);
    endtask

    task automatic run_check(input int exp_ok);
        int n;
        sb_push("chk_ok", exp_ok);
        cc = 1'b1;
        tick();
        cc = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!chk_done && n < 20);
        chk("chk_latency", 32'(n), 9);
        sb_pop(32'(chk_ok));
        tick();
        chk("chk_done_pulse", 32'(chk_done), 0);
    endtask

    task automatic commit();
        facedone = 1'b1;
        tick();
        facedone = 1'b0;
        tick();
    endtask

    task automatic verify(input int exp_valid);
        int n;
        sb_push("cube_valid", exp_valid);
        algstart = 1'b1;
        tick();
        algstart = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!cube_valid && n < 60);
        if (exp_valid != 0) chk("verify_latency", 32'(n), 55);
        sb_pop(32'(cube_valid));
        tick();
    endtask

    task automatic pulse_init();
        init = 1'b1;
        tick();
        init = 1'b0;
        tick();
    endtask

    initial begin
        logic [26:0] f;
        Reset = 1'b1; init = 1'b0; ds = 1'b0; cs = 1'b0; cc = 1'b0;
        facedone = 1'b0; algstart = 1'b0; col_valid = 1'b0; col_code = 3'd0;
        rd_addr = 6'd0;
        repeat (3) tick();
        Reset = 1'b0;

        // Reset state
        chk("rst_face_idx", 32'(face_idx), 0);
        chk("rst_cube_valid", 32'(cube_valid), 0);
        chk("rst_cube_err", 32'(cube_err), 0);
        chk("rst_chk_ok", 32'(chk_ok), 0);
        chk("rst_chk_done", 32'(chk_done), 0);
        chk("rst_col_ready", 32'(col_ready), 0);
        chk("rst_rd_color", 32'(rd_color), 7);
        for (int a = 0; a < 54; a++) rd(a, 7);

        // First face: solid color 0
        pulse_init();
        capture(solid(0));
        run_check(1);
        commit();
        chk("face_idx_1", 32'(face_idx), 1);
        chk("chk_ok_cleared", 32'(chk_ok), 0);
        rd(0, 0);
        rd(8, 0);
        rd(9, 7);

        // Center collides with face 0
        f = solid(1);
        f[12 +: 3] = 3'd0;
        capture(f);
        run_check(0);
        commit();
        chk("no_commit_face_idx", 32'(face_idx), 1);
        rd(13, 7);

        // Invalid code in the staged face
        f = solid(1);
        f[6 +: 3] = 3'd6;
        capture(f);
        run_check(0);

        // ds drops chk_ok and clears the stage
        capture(solid(1));
        run_check(1);
        ds = 1'b1;
        tick();
        ds = 1'b0;
        chk("ds_chk_ok", 32'(chk_ok), 0);
        commit();
        chk("ds_no_commit", 32'(face_idx), 1);
        run_check(0);

        // Remaining solid faces 1..5
        for (int c = 1; c < 6; c++) begin
            capture(solid(c));
            run_check(1);
            commit();
            chk($sformatf("face_idx_%0d", c + 1), 32'(face_idx), 32'(c + 1));
        end
        rd(17, 1);
        rd(31, 3);

        // Commit overflow
        commit();
        chk("ovf_cube_err", 32'(cube_err), 1);
        chk("ovf_face_idx", 32'(face_idx), 6);

        // Full verify
        verify(1);
`ifdef COLOR_HIST_EN
        chk("hist_bad_clean", 32'(hist_bad), 0);
`endif
        rd(49, 5);
        rd(53, 5);
        rd(54, 7);
        rd(63, 7);
        cs = 1'b1;
        tick();
        cs = 1'b0;
        chk("done_ignores_cs", 32'(col_ready), 0);
        chk("done_holds_valid", 32'(cube_valid), 1);

        // init mid-capture
        pulse_init();
        cs = 1'b1;
        tick();
        cs = 1'b0;
        for (int i = 0; i < 3; i++) begin
            col_valid = 1'b1;
            col_code  = 3'(i);
            tick();
        end
        col_valid = 1'b0;
        chk("mid_capture_ready", 32'(col_ready), 1);
        init = 1'b1;
        tick();
        init = 1'b0;
        chk("init_col_ready", 32'(col_ready), 0);
        chk("init_face_idx", 32'(face_idx), 0);
        chk("init_cube_valid", 32'(cube_valid), 0);
        chk("init_cube_err", 32'(cube_err), 0);
        rd(49, 7);

        // Verify with an incomplete cube
        capture(solid(0));
        run_check(1);
        commit();
        verify(0);
        chk("fail_cube_err", 32'(cube_err), 1);

`ifdef COLOR_HIST_EN
        // Color 0 appears 10 times, color 1 only 8 times
        pulse_init();
        for (int c = 0; c < 6; c++) begin
            f = solid(c);
            if (c == 1) f[0 +: 3] = 3'd0;
            capture(f);
            run_check(1);
            commit();
        end
        chk("hist_face_idx", 32'(face_idx), 6);
        verify(0);
        chk("hist_cube_err", 32'(cube_err), 1);
        chk("hist_bad", 32'(hist_bad), 32'h3);
`endif

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL sb_leftover: observed=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
